// File: rtl/cpu_pkg.sv
// Shared pipeline types: MEM/WB register layouts and the write-back trace entry format.
package cpu_pkg;

    localparam int TRACE_TS_W = 32;

    typedef struct packed {
        logic WB_reg_write;
        logic WB_mem_to_reg;
    } mem_wb_control_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] ALU_result;
        logic [4:0]  rd;
    } mem_wb_data_t;

    typedef struct packed {
        logic [TRACE_TS_W-1:0] ts;
        logic [4:0]            rd;
        logic [31:0]           value;
        logic                  from_mem;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO with wrap-bit pointers.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // A pop on a full FIFO frees the slot, so the push in that same cycle still lands.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back stage trace tap: timestamps every architectural register write and queues it
// for a consumer; never stalls the pipeline, drops (and counts) captures when the queue is full.
module wb_trace_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = TRACE_TS_W,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  mem_wb_control_t          wb_ctrl_i,
    input  mem_wb_data_t             wb_data_i,
    output logic                     trc_valid_o,
    input  logic                     trc_ready_i,
    output trace_entry_t             trc_entry_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);
    logic [TS_W-1:0]   ts_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;
    logic              capture;
    logic              pop;
    logic              push;
    logic              drop;
    logic              empty;
    trace_entry_t      wdata;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end

    assign capture = en_i && wb_ctrl_i.WB_reg_write && (wb_data_i.rd != 5'd0);
    assign pop     = trc_valid_o && trc_ready_i;
    assign push    = capture && (!full_o || pop);
    assign drop    = capture && full_o && !pop;

    // Narrower timestamp counters are zero-extended into the fixed-width entry field.
    always_comb begin
        wdata          = '0;
        wdata.ts       = TRACE_TS_W'(ts_q);
        wdata.rd       = wb_data_i.rd;
        wdata.value    = wb_ctrl_i.WB_mem_to_reg ? wb_data_i.read_data : wb_data_i.ALU_result;
        wdata.from_mem = wb_ctrl_i.WB_mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (trc_entry_o),
        .count (count_o),
        .full  (full_o),
        .empty (empty)
    );

    assign trc_valid_o = !empty;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a 32-bit-timestamp instance and an 8-bit-timestamp
// instance share stimulus and are compared against a queue-based reference model.
module tb_wb_trace_buffer;
    import cpu_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    typedef struct {
        logic [31:0] ts;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        from_mem;
    } exp_entry_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en_i = 1'b0;
    logic            clear_i = 1'b0;
    mem_wb_control_t wb_ctrl_i = '0;
    mem_wb_data_t    wb_data_i = '0;
    logic            trc_ready_i = 1'b0;

    logic               trc_valid_o, trc_valid8;
    trace_entry_t       trc_entry_o, trc_entry8;
    logic [4:0]         count_o, count8;
    logic               full_o, full8;
    logic               overflow_o, overflow8;
    logic [DROP_W-1:0]  drop_cnt_o, drop_cnt8;

    exp_entry_t        model_q[$];
    logic [31:0]       model_ts;
    logic [DROP_W-1:0] model_drops;
    logic              model_ovf;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .TS_W(32), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .wb_ctrl_i(wb_ctrl_i), .wb_data_i(wb_data_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_entry_o(trc_entry_o),
        .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .TS_W(8), .DROP_W(DROP_W)) dut8 (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .wb_ctrl_i(wb_ctrl_i), .wb_data_i(wb_data_i),
        .trc_valid_o(trc_valid8), .trc_ready_i(trc_ready_i), .trc_entry_o(trc_entry8),
        .count_o(count8), .full_o(full8), .overflow_o(overflow8), .drop_cnt_o(drop_cnt8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("valid", 64'(trc_valid_o), 64'(model_q.size() != 0));
        checkOutput("count", 64'(count_o), 64'(model_q.size()));
        checkOutput("full", 64'(full_o), 64'(model_q.size() == DEPTH));
        checkOutput("overflow", 64'(overflow_o), 64'(model_ovf));
        checkOutput("drop_cnt", 64'(drop_cnt_o), 64'(model_drops));
        checkOutput("valid8", 64'(trc_valid8), 64'(model_q.size() != 0));
        checkOutput("count8", 64'(count8), 64'(model_q.size()));
        checkOutput("drop_cnt8", 64'(drop_cnt8), 64'(model_drops));
        if (model_q.size() != 0) begin
            checkOutput("head_ts", 64'(trc_entry_o.ts), 64'(model_q[0].ts));
            checkOutput("head_rd", 64'(trc_entry_o.rd), 64'(model_q[0].rd));
            checkOutput("head_value", 64'(trc_entry_o.value), 64'(model_q[0].value));
            checkOutput("head_from_mem", 64'(trc_entry_o.from_mem), 64'(model_q[0].from_mem));
            checkOutput("head8_ts", 64'(trc_entry8.ts), 64'(model_q[0].ts[7:0]));
            checkOutput("head8_value", 64'(trc_entry8.value), 64'(model_q[0].value));
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge, then compare.
    task automatic applyStimulus(input logic en, input logic rw, input logic m2r, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rdat,
                                 input logic ready, input logic clr);
        logic       cap;
        logic       pop_m;
        exp_entry_t e;
        en_i                    = en;
        wb_ctrl_i.WB_reg_write  = rw;
        wb_ctrl_i.WB_mem_to_reg = m2r;
        wb_data_i.rd            = rd;
        wb_data_i.ALU_result    = alu;
        wb_data_i.read_data     = rdat;
        trc_ready_i             = ready;
        clear_i                 = clr;
        cap   = en && rw && (rd != 5'd0);
        pop_m = (model_q.size() != 0) && ready;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_drops = '0;
            model_ts    = '0;
        end else begin
            if (clr) begin
                model_q.delete();
                model_ovf   = 1'b0;
                model_drops = '0;
            end else begin
                if (pop_m) void'(model_q.pop_front());
                if (cap) begin
                    if (model_q.size() < DEPTH) begin
                        e.ts       = model_ts;
                        e.rd       = rd;
                        e.value    = m2r ? rdat : alu;
                        e.from_mem = m2r;
                        model_q.push_back(e);
                    end else begin
                        model_ovf = 1'b1;
                        if (model_drops != {DROP_W{1'b1}}) model_drops = model_drops + 1'b1;
                    end
                end
            end
            model_ts = model_ts + 1;
        end
        #1;
        compareAll();
    endtask

    task automatic idle(input logic ready);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, ready, 1'b0);
    endtask

    task automatic capture(input logic [4:0] rd, input logic [31:0] alu, input logic ready);
        applyStimulus(1'b1, 1'b1, 1'b0, rd, alu, $urandom, ready, 1'b0);
    endtask

    initial begin
        logic [31:0] prev_ts;
        logic        en_r, rw_r, m2r_r, rdy_r;
        logic [4:0]  rd_r;

        model_ts    = '0;
        model_drops = '0;
        model_ovf   = 1'b0;

        // Reset for three cycles, then a capture at timestamp 7.
        reset = 1'b1;
        repeat (3) idle(1'b0);
        checkOutput("reset_valid", 64'(trc_valid_o), 64'd0);
        checkOutput("reset_count", 64'(count_o), 64'd0);
        reset = 1'b0;
        repeat (7) idle(1'b0);
        capture(5'd5, 32'hDEADBEEF, 1'b0);
        checkOutput("first_valid", 64'(trc_valid_o), 64'd1);
        checkOutput("first_ts", 64'(trc_entry_o.ts), 64'd7);
        checkOutput("first_value", 64'(trc_entry_o.value), 64'hDEADBEEF);
        checkOutput("first_count", 64'(count_o), 64'd1);
        idle(1'b1);

        // Filtering: x0 writes, no reg_write and disabled capture produce nothing.
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'h11, 32'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd3, 32'h11, 32'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd3, 32'h11, 32'h22, 1'b0, 1'b0);
        checkOutput("filter_count", 64'(count_o), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 32'h1, 32'h12345678, 1'b0, 1'b0);
        checkOutput("mem_value", 64'(trc_entry_o.value), 64'h12345678);
        checkOutput("mem_from_mem", 64'(trc_entry_o.from_mem), 64'd1);
        idle(1'b1);

        // Fill to full, overflow by two, then push and pop together while full.
        for (int i = 0; i < 18; i++) begin
            capture(5'((i % 31) + 1), $urandom, 1'b0);
            if (i == 15) begin
                checkOutput("fill_full", 64'(full_o), 64'd1);
                checkOutput("fill_count", 64'(count_o), 64'd16);
            end
        end
        checkOutput("fill_overflow", 64'(overflow_o), 64'd1);
        checkOutput("fill_drops", 64'(drop_cnt_o), 64'd2);
        capture(5'd7, 32'hCAFE0001, 1'b1);
        checkOutput("pushpop_count", 64'(count_o), 64'd16);
        checkOutput("pushpop_drops", 64'(drop_cnt_o), 64'd2);
        repeat (18) idle(1'b1);

        // Clear with a capture in the same cycle; timestamp keeps running.
        capture(5'd1, 32'hA, 1'b0);
        prev_ts = model_ts - 1;
        capture(5'd2, 32'hB, 1'b0);
        capture(5'd3, 32'hC, 1'b0);
        prev_ts = model_ts - 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 32'hD, 32'h0, 1'b1, 1'b1);
        checkOutput("clear_count", 64'(count_o), 64'd0);
        checkOutput("clear_valid", 64'(trc_valid_o), 64'd0);
        checkOutput("clear_overflow", 64'(overflow_o), 64'd0);
        checkOutput("clear_drops", 64'(drop_cnt_o), 64'd0);
        capture(5'd6, 32'hE, 1'b0);
        checkOutput("clear_ts_gap", 64'(trc_entry_o.ts), 64'(prev_ts + 32'd2));

        // Random traffic long enough to wrap pointers and the 8-bit timestamp.
        for (int i = 0; i < 360; i++) begin
            en_r  = ($urandom_range(0, 9) != 0);
            rw_r  = ($urandom_range(0, 3) != 0);
            rd_r  = 5'($urandom_range(0, 31));
            m2r_r = 1'($urandom_range(0, 1));
            rdy_r = 1'($urandom_range(0, 1));
            if (model_ts[7:0] == 8'hFF || model_ts[7:0] == 8'h00) begin
                en_r = 1'b1;
                rw_r = 1'b1;
                if (rd_r == 5'd0) rd_r = 5'd17;
            end
            applyStimulus(en_r, rw_r, m2r_r, rd_r, $urandom, $urandom, rdy_r, 1'b0);
        end

        // Reset mid-stream with buffered entries.
        capture(5'd8, 32'h8, 1'b0);
        reset = 1'b1;
        capture(5'd9, 32'h9, 1'b0);
        checkOutput("midreset_valid", 64'(trc_valid_o), 64'd0);
        checkOutput("midreset_count", 64'(count_o), 64'd0);
        checkOutput("midreset_full", 64'(full_o), 64'd0);
        checkOutput("midreset_overflow", 64'(overflow8), 64'd0);
        reset = 1'b0;
        capture(5'd10, 32'h10, 1'b0);
        checkOutput("postreset_ts", 64'(trc_entry_o.ts), 64'd0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
